// File: rtl/rvv_backend_div_issue_arb.sv
// Round-robin issue arbiter that shares one iterative vector divider between several
// DIV reservation-station ports, and steers in-order divider results back to the issuing port.
module rvv_backend_div_issue_arb #(
  parameter int NUM_REQ   = 2,
  parameter int OUT_DEPTH = 4,
  parameter int TAG_W     = 5
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_trap_flush,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]   i_req_tag,
  output logic [NUM_REQ-1:0]         o_req_ready,
  output logic                       o_unit_valid,
  input  logic                       i_unit_ready,
  output logic [$clog2(NUM_REQ)-1:0] o_unit_sel,
  output logic [TAG_W-1:0]           o_unit_tag,
  input  logic                       i_unit_res_valid,
  output logic                       o_unit_res_ready,
  output logic [NUM_REQ-1:0]         o_res_valid,
  input  logic [NUM_REQ-1:0]         i_res_ready,
  output logic                       o_proto_err
);

  localparam int SEL_W = $clog2(NUM_REQ);
  localparam int PTR_W = $clog2(OUT_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SEL_W-1:0]   r_sel;
  logic [TAG_W-1:0]   r_tag;
  logic [SEL_W-1:0]   r_rr_ptr;
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [CNT_W-1:0]   r_cnt;
  logic [SEL_W-1:0]   r_fifo [OUT_DEPTH];
  logic               r_proto_err;

  logic               w_grant_any;
  logic [SEL_W-1:0]   w_winner;
  logic               w_load;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_cnt_nz;
  logic [SEL_W-1:0]   w_head;
  logic [SEL_W-1:0]   w_sel_inc;

  assign w_full    = (r_cnt == CNT_W'(OUT_DEPTH));
  assign w_cnt_nz  = (r_cnt != {CNT_W{1'b0}});
  assign w_head    = r_fifo[r_rptr];
  assign w_sel_inc = (r_sel == SEL_W'(NUM_REQ - 1)) ? {SEL_W{1'b0}} : (r_sel + SEL_W'(1));

  // Descending scan so the requester closest to r_rr_ptr is written last and wins.
  always_comb begin
    w_grant_any = 1'b0;
    w_winner    = {SEL_W{1'b0}};
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req_valid[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
        w_grant_any = 1'b1;
        w_winner    = SEL_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant_any && !w_full && !i_trap_flush) begin
          w_load      = 1'b1;
          w_state_nxt = S_HOLD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_HOLD: begin
        if (i_unit_ready && !i_trap_flush) begin
          w_push      = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (i_trap_flush) begin
      w_state_nxt = S_IDLE;
    end
  end

  assign o_unit_valid = (r_state == S_HOLD) && !i_trap_flush;
  assign o_unit_sel   = r_sel;
  assign o_unit_tag   = r_tag;
  assign o_proto_err  = r_proto_err;

  always_comb begin
    o_req_ready = {NUM_REQ{1'b0}};
    if (o_unit_valid && i_unit_ready) begin
      o_req_ready[r_sel] = 1'b1;
    end
  end

  // Results come back in issue order, so the FIFO head names the destination port.
  always_comb begin
    o_res_valid = {NUM_REQ{1'b0}};
    if (i_unit_res_valid && w_cnt_nz && !i_trap_flush) begin
      o_res_valid[w_head] = 1'b1;
    end
  end

  assign o_unit_res_ready = i_res_ready[w_head] && w_cnt_nz && !i_trap_flush;
  assign w_pop            = i_unit_res_valid && o_unit_res_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sel    <= {SEL_W{1'b0}};
      r_tag    <= {TAG_W{1'b0}};
      r_rr_ptr <= {SEL_W{1'b0}};
    end else if (i_trap_flush) begin
      r_rr_ptr <= {SEL_W{1'b0}};
    end else begin
      if (w_load) begin
        r_sel <= w_winner;
        r_tag <= i_req_tag[int'(w_winner) * TAG_W +: TAG_W];
      end
      if (w_push) begin
        r_rr_ptr <= w_sel_inc;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr <= {PTR_W{1'b0}};
      r_rptr <= {PTR_W{1'b0}};
      r_cnt  <= {CNT_W{1'b0}};
      for (int i = 0; i < OUT_DEPTH; i++) begin
        r_fifo[i] <= {SEL_W{1'b0}};
      end
    end else if (i_trap_flush) begin
      r_wptr <= {PTR_W{1'b0}};
      r_rptr <= {PTR_W{1'b0}};
      r_cnt  <= {CNT_W{1'b0}};
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= r_sel;
        r_wptr         <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_proto_err <= 1'b0;
    end else if (i_unit_res_valid && !w_cnt_nz) begin
      r_proto_err <= 1'b1;
    end else begin
      r_proto_err <= r_proto_err;
    end
  end

endmodule
